// File: rtl/vector_operand_stage.sv
// vector_operand_stage: ID/EX vector operand latch with 2-entry skid buffer and writeback forwarding
module vector_operand_stage #(
    parameter int N      = 64,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [N-1:0]      inSrcA,
    input  logic [N-1:0]      inSrcB,
    input  logic [REG_AW-1:0] inRs1,
    input  logic [REG_AW-1:0] inRs2,
    input  logic [REG_AW-1:0] inRd,
    input  logic              inWriteEn,
    input  logic [1:0]        inAluControl,
    input  logic              fwdValid,
    input  logic [REG_AW-1:0] fwdRd,
    input  logic [N-1:0]      fwdData,
    output logic              outValid,
    input  logic              outReady,
    output logic [N-1:0]      regData1,
    output logic [N-1:0]      regData2,
    output logic [1:0]        aluControl,
    output logic [REG_AW-1:0] outRd,
    output logic              outWriteEn
);
    typedef struct packed {
        logic [N-1:0]      srca;
        logic [N-1:0]      srcb;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic [1:0]        alu;
    } entry_t;

    entry_t main_q, skid_q, main_d, skid_d, in_f, main_f, skid_f;
    logic   main_v, skid_v, main_vd, skid_vd, rdy_q;
    logic   acc, xfer;

    function automatic entry_t fwd(input entry_t e);
        entry_t r;
        r = e;
        if (fwdValid && fwdRd == e.rs1) r.srca = fwdData;
        if (fwdValid && fwdRd == e.rs2) r.srcb = fwdData;
        return r;
    endfunction

    assign acc    = inValid & rdy_q;
    assign xfer   = main_v & outReady;
    assign in_f   = fwd('{inSrcA, inSrcB, inRs1, inRs2, inRd, inWriteEn, inAluControl});
    assign main_f = fwd(main_q);
    assign skid_f = fwd(skid_q);

    // next-state: refill main from skid first (ordering), park input in skid when main is stuck
    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        main_vd = main_v;
        skid_vd = skid_v;
        if (flush) begin
            main_vd = 1'b0;
            skid_vd = 1'b0;
        end else begin
            if (!main_v || xfer) begin
                if (skid_v) begin
                    main_d  = skid_f;
                    main_vd = 1'b1;
                    skid_vd = 1'b0;
                end else if (acc) begin
                    main_d  = in_f;
                    main_vd = 1'b1;
                end else begin
                    main_vd = 1'b0;
                end
            end else begin
                main_d = main_f;
            end
            if (acc && main_v && !outReady) begin
                skid_d  = in_f;
                skid_vd = 1'b1;
            end else if (skid_v && skid_vd) begin
                skid_d = skid_f;
            end
        end
    end

    // state registers; inReady is registered from the next skid occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            main_v <= main_vd;
            skid_v <= skid_vd;
            rdy_q  <= !skid_vd;
        end
    end

    assign inReady    = rdy_q;
    assign outValid   = main_v;
    assign regData1   = main_q.srca;
    assign regData2   = main_q.srcb;
    assign aluControl = main_q.alu;
    assign outRd      = main_q.rd;
    assign outWriteEn = main_q.we;
endmodule

// File: doc/vector_operand_stage.md
Name: vector_operand_stage

Overview:
- ID/EX pipeline stage of the vector datapath: latches decoded vector operands, ALU control and destination tag, then drives the operand and control inputs of the vectorial ALU.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops an instruction.
- Applies writeback forwarding both when an entry is captured and while it is parked in the stage.
- Supports a synchronous pipeline flush.

Parameters:
- N, 64, vector register width in bits (lanes packed inside the word).
- REG_AW, 4, vector register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  discard all held entries.
- inValid  input  1  upstream entry valid.
- inReady  output  1  stage can accept an entry.
- inSrcA  input  N  register-file read data, operand 1.
- inSrcB  input  N  register-file read data, operand 2.
- inRs1  input  REG_AW  source register address, operand 1.
- inRs2  input  REG_AW  source register address, operand 2.
- inRd  input  REG_AW  destination register.
- inWriteEn  input  1  instruction writes inRd.
- inAluControl  input  2  00 add, 01 sub, 10 xor, 11 ror.
- fwdValid  input  1  writeback result valid this cycle.
- fwdRd  input  REG_AW  writeback destination.
- fwdData  input  N  writeback data.
- outValid  output  1  ALU-side entry valid.
- outReady  input  1  downstream accepts the entry.
- regData1  output  N  operand 1 to the ALU.
- regData2  output  N  operand 2 to the ALU.
- aluControl  output  2  ALU operation select.
- outRd  output  REG_AW  destination tag.
- outWriteEn  output  1  destination write enable.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each holds srcA, srcB, rs1, rs2, rd, writeEn, aluControl and a valid bit.
- Reset (rst=0, asynchronous):
  - both valid bits cleared.
  - All stored fields cleared to 0, so outValid=0, regData1=regData2=0, aluControl=00, outRd=0, outWriteEn=0.
  - inReady=1 one cycle after reset release; 0 during reset.
- inReady = !skidValid (registered; no combinational path from outReady).
- Accept = inValid & inReady. Transfer = outValid & outReady.
- Main register update each edge, non-flush:
  - If !mainValid or Transfer: main loads skid if skidValid; else main loads the input if Accept; else mainValid clears.
  - Otherwise main holds.
- Skid register:
  - Loads the input when Accept and main is occupied and not draining (mainValid & !outReady).
  - Clears when it moves to main.
- Latency: an accepted entry appears on the outputs the next cycle. Throughput is 1 per cycle when outReady=1.
- Ordering: entries leave strictly in arrival order.
- Forwarding at capture:
  - If fwdValid & fwdRd==inRs1, the stored srcA is fwdData; same for rs2/srcB.
  - Both operands may match simultaneously.
- Forwarding while held:
  - Every cycle, any valid main or skid entry whose rs1 or rs2 equals fwdRd (with fwdValid=1) overwrites that operand with fwdData.
  - The held-entry update and a move skid→main in the same cycle must both apply; the moved entry carries the forwarded value.
- Flush (synchronous, highest priority after reset):
  - Next edge clears both valids.
  - A concurrent Accept is discarded.
  - Transfer in the flush cycle still counts for downstream.
- Outputs are registered straight from the main entry; regData/aluControl are don't-care-stable (held) while outValid=0.
- No lane arithmetic is performed here; widths pass through unchanged.

Test Plan:
- Reset mid-stream with two entries held (outValid=1, inReady=0), assert rst=0 → outValid=0, all outputs 0 immediately; inReady=1 after release.
- Streaming with outReady=1: entries A,B,C on consecutive cycles → appear on consecutive cycles, one-cycle latency, inReady stays 1.
- Stall: outReady=0, send A then B → A on outputs, B in skid, inReady=0. Raise outReady → B emerges the next cycle in order, nothing lost.
- Capture forward: inRs1=3, inSrcA=0x1111, fwdValid=1, fwdRd=3, fwdData=0xDEAD_BEEF_0000_0001 → regData1=0xDEAD_BEEF_0000_0001, regData2=inSrcB.
- Held forward: entry with rs2=5 stalled in skid, then fwdRd=5, fwdData=0x0123_4567_89AB_CDEF → when it drains, regData2=0x0123_4567_89AB_CDEF.
- Flush with inValid=1 and both entries full → next cycle outValid=0, inReady=1, and the flushed input never appears.
